// File: rtl/tile_map_scheduler.sv
// Tile-position memory write sequencer: host single-tile writes and a bulk fill engine share a per-blank write budget.
// Latency: grant at edge k, strobe/ack during cycle k+1; host waits (WrReq held) until a blank slot and arbitration win.
module tile_map_scheduler #(
    parameter int TILE_COUNT       = 300,
    parameter int WRITES_PER_BLANK = 64
) (
    input  logic       MasterCLK,
    input  logic       Reset,
    input  logic       FrameBlank,
    input  logic       WrReq,
    input  logic [8:0] WrAddr,
    input  logic [4:0] WrData,
    output logic       WrAck,
    output logic       AddrError,
    input  logic       FillStart,
    input  logic [4:0] FillData,
    output logic       FillBusy,
    output logic       FillDone,
    output logic [8:0] TilesPositionAddress,
    output logic [4:0] TilesPositionData,
    output logic       TilesPositionWrite
);
    localparam int BW = $clog2(WRITES_PER_BLANK + 1);
    localparam logic [BW-1:0] BUDGET_FULL = BW'(WRITES_PER_BLANK);
    localparam logic [9:0]    TILE_LIM    = 10'(TILE_COUNT);

    logic [BW-1:0] budget;
    logic          blank_q;
    logic [8:0]    fill_cnt;
    logic [4:0]    fill_val;
    logic          last_fill;

    logic slot, host_elig, fill_elig, grant_host, grant_fill;
    logic addr_ok, fill_last, fill_accept;

    always_comb begin
        slot        = blank_q && (budget != '0) && !WrAck;
        host_elig   = WrReq && !WrAck;
        fill_elig   = FillBusy;
        // On a tie the requester that did not win last time goes next.
        grant_host  = slot && host_elig && (!fill_elig || last_fill);
        grant_fill  = slot && fill_elig && (!host_elig || !last_fill);
        addr_ok     = {1'b0, WrAddr} < TILE_LIM;
        fill_last   = {1'b0, fill_cnt} == (TILE_LIM - 10'd1);
        // The FillDone cycle still counts as busy for new starts.
        fill_accept = FillStart && !FillBusy && !FillDone;
    end

    always_ff @(posedge MasterCLK or negedge Reset) begin
        if (!Reset) begin
            budget               <= '0;
            blank_q              <= 1'b0;
            fill_cnt             <= '0;
            fill_val             <= '0;
            last_fill            <= 1'b1;
            WrAck                <= 1'b0;
            AddrError            <= 1'b0;
            FillBusy             <= 1'b0;
            FillDone             <= 1'b0;
            TilesPositionAddress <= '0;
            TilesPositionData    <= '0;
            TilesPositionWrite   <= 1'b0;
        end else begin
            blank_q            <= FrameBlank;
            WrAck              <= 1'b0;
            AddrError          <= 1'b0;
            FillDone           <= 1'b0;
            TilesPositionWrite <= 1'b0;

            if (FrameBlank && !blank_q)
                budget <= BUDGET_FULL;
            else if (grant_fill || (grant_host && addr_ok))
                budget <= budget - BW'(1);

            if (grant_host) begin
                last_fill <= 1'b0;
                WrAck     <= 1'b1;
                if (addr_ok) begin
                    TilesPositionAddress <= WrAddr;
                    TilesPositionData    <= WrData;
                    TilesPositionWrite   <= 1'b1;
                end else begin
                    AddrError <= 1'b1;
                end
            end

            if (grant_fill) begin
                last_fill            <= 1'b1;
                TilesPositionAddress <= fill_cnt;
                TilesPositionData    <= fill_val;
                TilesPositionWrite   <= 1'b1;
                if (fill_last) begin
                    fill_cnt <= '0;
                    FillBusy <= 1'b0;
                    FillDone <= 1'b1;
                end else begin
                    fill_cnt <= fill_cnt + 9'd1;
                end
            end

            if (fill_accept) begin
                fill_val <= FillData;
                fill_cnt <= '0;
                FillBusy <= 1'b1;
            end
        end
    end
endmodule
